buffer_writer: RTL
==================

// Module: buffer_writer
// PURPOSE
//  Write side of the double-buffered frame store. Accepts rectangle-fill commands, emits one
//  pixel write per cycle into the back buffer (raster order), and at end of a frame's command
//  list flips the front/back select only at the scan-out frame boundary. This prevents tearing.
//  Sits between the drawing/command source and the two buffer memories. The scan-out reader
//  consumes buf_sel and supplies frame_end.
// PARAMETERS
//  WIDTH       `WIDTH       visible pixels per line
//  HEIGHT      `HEIGHT      visible lines per frame
//  PIXEL_SIZE  `PIXEL_SIZE  bits per pixel
//  XW          $clog2(WIDTH)   x coordinate width (derived; do not override)
//  YW          $clog2(HEIGHT)  y coordinate width (derived; do not override)
// PORTS
//  clk        in   1           single clock; every register is on posedge clk
//  resetn     in   1           asynchronous, active-low reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           writer can accept a command (high only in IDLE)
//  cmd_x0     in   XW          left edge, inclusive
//  cmd_y0     in   YW          top edge, inclusive
//  cmd_x1     in   XW          right edge, inclusive
//  cmd_y1     in   YW          bottom edge, inclusive
//  cmd_color  in   PIXEL_SIZE  fill value
//  cmd_last   in   1           last command of this frame; request a swap after the fill
//  frame_end  in   1           1-cycle pulse from scan-out at the last visible pixel
//  wr_en      out  1           pixel write strobe
//  wr_buf     out  1           target buffer; always equals ~buf_sel
//  wr_x       out  XW          write column
//  wr_y       out  YW          write row
//  wr_data    out  PIXEL_SIZE  write value
//  buf_sel    out  1           front (displayed) buffer index
//  busy       out  1           high in FILL or SWAP_WAIT
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; buf_sel=0; wr_en=0; wr_x=0, wr_y=0, wr_data=0; busy=0.
//   - cmd_ready is high one cycle after reset is released.
//   - Back-buffer contents are not cleared. A fill interrupted by reset is abandoned.
//  FSM states:
//   - IDLE:
//     - cmd_valid&&cmd_ready latches the command, clipped: x1c=min(x1,WIDTH-1), y1c=min(y1,HEIGHT-1).
//     - Empty rect (x0>x1c, y0>y1c, x0>=WIDTH or y0>=HEIGHT): no writes; go to SWAP_WAIT if cmd_last, else stay in IDLE.
//     - Otherwise go to FILL.
//   - FILL:
//     - One write per cycle: x runs x0..x1c, then wraps to x0 and y increments, until (x1c,y1c).
//     - After the last write: go to SWAP_WAIT if the latched last flag is set, else IDLE.
//   - SWAP_WAIT:
//     - wr_en=0. On a cycle with frame_end=1: buf_sel toggles at that edge and state goes to IDLE.
//  Latency:
//   - Command accepted at edge N. Writes are valid in cycles N+1..N+w*h (w=x1c-x0+1, h=y1c-y0+1).
//   - cmd_ready rises in cycle N+w*h+1.
//  Ordering and boundary rules:
//   - wr_en is never high outside FILL.
//   - wr_buf is constant during a fill and the swap wait.
//   - frame_end in IDLE or FILL is ignored and no swap is remembered. Only SWAP_WAIT acts on it.
//   - frame_end on the same cycle as the final FILL write is ignored; the swap waits for the next pulse.
//   - cmd_valid while not ready is held off; the command is not dropped or latched.
//   - Counter arithmetic is at XW/YW width with no wrap past x1c/y1c. x1c=WIDTH-1 must not overflow XW.
// STRUCTURE
//  Shared constants in vga_defs.v:
//   - FSM encodings BW_IDLE, BW_FILL, BW_SWAP_WAIT.
//   - Coordinate-width macros derived from `WIDTH and `HEIGHT.
//  One sub-module, rect_scanner:
//   - Loadable x/y raster counter with clip logic and a 'done' output.
//   - buffer_writer holds the FSM, the command latch and buf_sel.
// TESTING
//  T1 reset/ready: hold resetn=0 mid-FILL -> wr_en=0, buf_sel=0, busy=0 immediately;
//     cmd_ready=1 one cycle after release.
//  T2 small fill: (x0,y0,x1,y1)=(2,3,4,4), color=5, cmd_last=0 -> 6 writes (2,3)(3,3)(4,3)(2,4)(3,4)(4,4),
//     wr_buf=1, cmd_ready back 7 cycles after accept, buf_sel unchanged.
//  T3 clip: x1=WIDTH+7, y1=y0 -> writes end at (WIDTH-1,y0). (x0=WIDTH) -> zero writes, 1-cycle return to IDLE.
//  T4 swap timing: cmd_last=1 rect of 4 px, frame_end pulsed 10 cycles later -> busy through the wait,
//     buf_sel toggles 0->1 at the pulse edge, next fill has wr_buf=0.
//  T5 coincident events: frame_end on the final write cycle and again 20 cycles later -> toggle only at the second pulse.
//     frame_end during IDLE -> no toggle.
//  T6 backpressure: cmd_valid held through a full fill -> exactly one command accepted per IDLE cycle,
//     no duplicate or lost fills.

Source files
------------

// File: rtl/buffer_writer_pkg.sv
// Shared definitions for the double-buffered frame-store write side:
// default raster geometry, FSM encoding and coordinate-width helper.
package buffer_writer_pkg;

    localparam int BW_WIDTH      = 40;
    localparam int BW_HEIGHT     = 30;
    localparam int BW_PIXEL_SIZE = 8;

    typedef enum logic [1:0] {
        BW_IDLE      = 2'd0,
        BW_FILL      = 2'd1,
        BW_SWAP_WAIT = 2'd2
    } bw_state_e;

    // A single-pixel dimension still needs a 1-bit coordinate bus.
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_writer_rect_scanner.sv
// Loadable raster counter for one rectangle fill: clips the far corner to the
// visible area, flags empty rectangles and reports the final pixel.
module rect_scanner
    import buffer_writer_pkg::*;
#(
    parameter int  WIDTH  = BW_WIDTH,
    parameter int  HEIGHT = BW_HEIGHT,
    localparam int XW     = coord_width(WIDTH),
    localparam int YW     = coord_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW-1:0] x1_i,
    input  logic [YW-1:0] y1_i,
    output logic          empty_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          done_o
);

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    logic [XW-1:0] x1c;
    logic [YW-1:0] y1c;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] x1c_q, x1c_d;
    logic [YW-1:0] y1c_q, y1c_d;

    always_comb begin
        x1c = (x1_i > XMAX) ? XMAX : x1_i;
        y1c = (y1_i > YMAX) ? YMAX : y1_i;
        empty_o = (x0_i > x1c) || (y0_i > y1c) ||
                  (32'(x0_i) >= 32'(WIDTH)) || (32'(y0_i) >= 32'(HEIGHT));
    end

    assign done_o = (x_q == x1c_q) && (y_q == y1c_q);
    assign x_o    = x_q;
    assign y_o    = y_q;

    // Counters never move past the clipped corner, so x_q+1 cannot overflow XW.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        x0_d  = x0_q;
        x1c_d = x1c_q;
        y1c_d = y1c_q;
        if (load_i) begin
            x_d   = x0_i;
            y_d   = y0_i;
            x0_d  = x0_i;
            x1c_d = x1c;
            y1c_d = y1c;
        end else if (step_i && !done_o) begin
            if (x_q == x1c_q) begin
                x_d = x0_q;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q   <= '0;
            y_q   <= '0;
            x0_q  <= '0;
            x1c_q <= '0;
            y1c_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            x0_q  <= x0_d;
            x1c_q <= x1c_d;
            y1c_q <= y1c_d;
        end
    end

endmodule

// File: rtl/buffer_writer.sv
// Write side of the double-buffered frame store: fills rectangles into the back
// buffer one pixel per cycle and flips buf_sel only on a scan-out frame_end.
module buffer_writer
    import buffer_writer_pkg::*;
#(
    parameter int  WIDTH      = BW_WIDTH,
    parameter int  HEIGHT     = BW_HEIGHT,
    parameter int  PIXEL_SIZE = BW_PIXEL_SIZE,
    localparam int XW         = coord_width(WIDTH),
    localparam int YW         = coord_width(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [XW-1:0]         cmd_x0,
    input  logic [YW-1:0]         cmd_y0,
    input  logic [XW-1:0]         cmd_x1,
    input  logic [YW-1:0]         cmd_y1,
    input  logic [PIXEL_SIZE-1:0] cmd_color,
    input  logic                  cmd_last,
    input  logic                  frame_end,
    output logic                  wr_en,
    output logic                  wr_buf,
    output logic [XW-1:0]         wr_x,
    output logic [YW-1:0]         wr_y,
    output logic [PIXEL_SIZE-1:0] wr_data,
    output logic                  buf_sel,
    output logic                  busy
);

    bw_state_e             state_q, state_d;
    logic                  buf_sel_q, buf_sel_d;
    logic [PIXEL_SIZE-1:0] color_q, color_d;
    logic                  last_q, last_d;
    logic                  armed_q;

    logic                  accept;
    logic                  scan_load;
    logic                  scan_step;
    logic                  scan_empty;
    logic                  scan_done;

    rect_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scanner (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (scan_load),
        .step_i  (scan_step),
        .x0_i    (cmd_x0),
        .y0_i    (cmd_y0),
        .x1_i    (cmd_x1),
        .y1_i    (cmd_y1),
        .empty_o (scan_empty),
        .x_o     (wr_x),
        .y_o     (wr_y),
        .done_o  (scan_done)
    );

    // armed_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = armed_q && (state_q == BW_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign wr_en     = (state_q == BW_FILL);
    assign busy      = (state_q == BW_FILL) || (state_q == BW_SWAP_WAIT);
    assign wr_buf    = ~buf_sel_q;
    assign wr_data   = color_q;
    assign buf_sel   = buf_sel_q;

    always_comb begin
        state_d   = state_q;
        buf_sel_d = buf_sel_q;
        color_d   = color_q;
        last_d    = last_q;
        scan_load = 1'b0;
        scan_step = 1'b0;
        unique case (state_q)
            BW_IDLE: begin
                if (accept) begin
                    color_d = cmd_color;
                    last_d  = cmd_last;
                    if (scan_empty) begin
                        state_d = cmd_last ? BW_SWAP_WAIT : BW_IDLE;
                    end else begin
                        scan_load = 1'b1;
                        state_d   = BW_FILL;
                    end
                end
            end
            BW_FILL: begin
                // frame_end is deliberately not looked at here, even on the final write.
                scan_step = 1'b1;
                if (scan_done) begin
                    state_d = last_q ? BW_SWAP_WAIT : BW_IDLE;
                end
            end
            BW_SWAP_WAIT: begin
                if (frame_end) begin
                    buf_sel_d = ~buf_sel_q;
                    state_d   = BW_IDLE;
                end
            end
            default: begin
                state_d = BW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= BW_IDLE;
            buf_sel_q <= 1'b0;
            color_q   <= '0;
            last_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_sel_q <= buf_sel_d;
            color_q   <= color_d;
            last_q    <= last_d;
            armed_q   <= 1'b1;
        end
    end

endmodule
